// File: rtl/subtractor_xbit_serial.sv
// Slice-serial subtractor: a - b - bor over DATA_WIDTH bits, SLICE_WIDTH bits per clock,
// built on the carry-lookahead adder with the borrow carried between cycles.

module adder_xbit_ahead #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_carry,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry
);
    logic [DATA_WIDTH-1:0] prop;
    logic [DATA_WIDTH-1:0] gen;
    logic [DATA_WIDTH:0]   carry;
    logic                  c_acc;
    logic                  p_acc;

    assign prop = i_num_a ^ i_num_b;
    assign gen  = i_num_a & i_num_b;

    // Each carry is the flattened sum-of-products over all lower generate/propagate terms.
    always_comb begin
        carry    = '0;
        c_acc    = 1'b0;
        p_acc    = 1'b0;
        carry[0] = i_carry;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c_acc = gen[i];
            p_acc = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                c_acc = c_acc | (p_acc & gen[j]);
                p_acc = p_acc & prop[j];
            end
            carry[i+1] = c_acc | (p_acc & i_carry);
        end
    end

    assign o_sum   = prop ^ carry[DATA_WIDTH-1:0];
    assign o_carry = carry[DATA_WIDTH];
endmodule

module subtractor_xbit_serial #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    output logic                  o_rdy,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_bor,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_bor,
    output logic                  o_ovf,
    output logic [1:0]            o_dbg_state
);
    localparam int N  = DATA_WIDTH / SLICE_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Handshakes: a request transfers on the rising edge where i_vld && o_rdy; a result
    // transfers on the rising edge where o_vld && i_rdy. Both readies/valids come from state only.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  a_q, b_q, res_q;
    logic [CW-1:0]          cnt_q;
    logic                   borrow_q, bor_q, ovf_q;
    logic [SLICE_WIDTH-1:0] a_sl, b_sl, sum_sl;
    logic                   cout_sl, cin_msb;

    assign a_sl = a_q[cnt_q*SLICE_WIDTH +: SLICE_WIDTH];
    assign b_sl = b_q[cnt_q*SLICE_WIDTH +: SLICE_WIDTH];

    adder_xbit_ahead #(.DATA_WIDTH(SLICE_WIDTH)) u_slice_add (
        .i_num_a (a_sl),
        .i_num_b (~b_sl),
        .i_carry (~borrow_q),
        .o_sum   (sum_sl),
        .o_carry (cout_sl)
    );

    // Carry into the slice MSB recovered from its sum bit: s = a ^ ~b ^ c.
    assign cin_msb = sum_sl[SLICE_WIDTH-1] ^ a_sl[SLICE_WIDTH-1] ^ ~b_sl[SLICE_WIDTH-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_vld) state_nxt = CALC;
            CALC:    if (cnt_q == LAST) state_nxt = DONE;
            DONE:    if (i_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bor_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_vld) begin
                a_q      <= i_num_a;
                b_q      <= i_num_b;
                borrow_q <= i_bor;
                cnt_q    <= '0;
            end else if (state == CALC) begin
                res_q[cnt_q*SLICE_WIDTH +: SLICE_WIDTH] <= sum_sl;
                borrow_q <= ~cout_sl;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    bor_q <= ~cout_sl;
                    ovf_q <= cin_msb ^ cout_sl;
                end
            end
        end
    end

    assign o_rdy       = (state == IDLE);
    assign o_vld       = (state == DONE);
    assign o_res       = res_q;
    assign o_bor       = bor_q;
    assign o_ovf       = ovf_q;
    assign o_dbg_state = state;
endmodule

// File: tb/tb_subtractor_xbit_serial.sv
// Directed bench for subtractor_xbit_serial at DATA_WIDTH=8, SLICE_WIDTH=4 (N=2).

module tb_subtractor_xbit_serial;
    localparam int DW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_vld = 1'b0;
    logic          i_rdy = 1'b0;
    logic          i_bor = 1'b0;
    logic [DW-1:0] i_num_a = '0;
    logic [DW-1:0] i_num_b = '0;
    logic          o_rdy, o_vld, o_bor, o_ovf;
    logic [DW-1:0] o_res;
    logic [1:0]    o_dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [DW+1:0] exp_q[$];

    subtractor_xbit_serial #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vld       (i_vld),
        .o_rdy       (o_rdy),
        .i_num_a     (i_num_a),
        .i_num_b     (i_num_b),
        .i_bor       (i_bor),
        .o_vld       (o_vld),
        .i_rdy       (i_rdy),
        .o_res       (o_res),
        .o_bor       (o_bor),
        .o_ovf       (o_ovf),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for o_vld; leaves the result held in DONE.
    task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic bor,
                            output int lat, output logic [DW+1:0] got);
        @(negedge clk);
        i_vld = 1'b1; i_num_a = a; i_num_b = b; i_bor = bor;
        @(posedge clk);
        @(negedge clk);
        i_vld = 1'b0;
        i_num_a = $urandom_range(0, 255); i_num_b = $urandom_range(0, 255);
        lat = 1;
        while (!o_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = {o_bor, o_ovf, o_res};
    endtask

    task automatic consume();
        i_rdy = 1'b1;
        @(negedge clk);
        i_rdy = 1'b0;
    endtask

    task automatic test_reset();
        int lat;
        logic [DW+1:0] got;
        drive_op(8'h00, 8'h01, 1'b0, lat, got);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1 || o_res !== 8'h00 || o_bor !== 1'b0 || o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_async vld=%b rdy=%b res=%h bor=%b ovf=%b want 0 1 00 0 0",
                     o_vld, o_rdy, o_res, o_bor, o_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vectors();
        logic [DW-1:0] va[6] = '{8'h05, 8'h10, 8'h00, 8'h00, 8'h80, 8'h7F};
        logic [DW-1:0] vb[6] = '{8'h03, 8'h01, 8'h01, 8'h7F, 8'h01, 8'hFF};
        logic          vc[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        // {bor, ovf, res} worked out by hand
        exp_q.push_back({1'b0, 1'b0, 8'h02});
        exp_q.push_back({1'b0, 1'b0, 8'h0F});
        exp_q.push_back({1'b1, 1'b0, 8'hFF});
        exp_q.push_back({1'b1, 1'b0, 8'h80});
        exp_q.push_back({1'b0, 1'b1, 8'h7F});
        exp_q.push_back({1'b1, 1'b1, 8'h80});
        for (int i = 0; i < 6; i++) begin
            int lat;
            logic [DW+1:0] got, exp;
            drive_op(va[i], vb[i], vc[i], lat, got);
            exp = exp_q.pop_front();
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL latency_%0d got=%0d want=3", i, lat);
            end
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL vector_%0d a=%h b=%h bor=%b got={bor,ovf,res}=%b want=%b",
                         i, va[i], vb[i], vc[i], got, exp);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [DW+1:0] got;
        drive_op(8'h10, 8'h01, 1'b0, lat, got);
        checks++;
        if (got !== {1'b0, 1'b0, 8'h0F}) begin
            failures++;
            $display("FAIL bp_result got=%b want=%b", got, {1'b0, 1'b0, 8'h0F});
        end
        for (int i = 0; i < 5; i++) begin
            i_vld = ~i_vld;
            i_num_a = $urandom_range(0, 255);
            i_num_b = $urandom_range(0, 255);
            @(negedge clk);
            checks++;
            if ({o_bor, o_ovf, o_res} !== {1'b0, 1'b0, 8'h0F} || o_vld !== 1'b1 || o_rdy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d res=%h bor=%b ovf=%b vld=%b rdy=%b want 0f 0 0 1 0",
                         i, o_res, o_bor, o_ovf, o_vld, o_rdy);
            end
        end
        i_vld = 1'b0;
        consume();
        checks++;
        if (o_rdy !== 1'b1 || o_vld !== 1'b0) begin
            failures++;
            $display("FAIL bp_release rdy=%b vld=%b want 1 0", o_rdy, o_vld);
        end
        drive_op(8'h80, 8'h01, 1'b0, lat, got);
        checks++;
        if (got !== {1'b0, 1'b1, 8'h7F} || lat !== 3) begin
            failures++;
            $display("FAIL bp_next got=%b lat=%0d want=%b lat=3", got, lat, {1'b0, 1'b1, 8'h7F});
        end
        consume();
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        logic [DW+1:0] got;
        int saw_vld = 0;
        @(negedge clk);
        i_vld = 1'b1; i_num_a = 8'h00; i_num_b = 8'h01; i_bor = 1'b0;
        @(posedge clk);
        #2 i_vld = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1 || o_res !== 8'h00 || o_bor !== 1'b0 || o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid vld=%b rdy=%b res=%h bor=%b ovf=%b want 0 1 00 0 0",
                     o_vld, o_rdy, o_res, o_bor, o_ovf);
        end
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_vld) saw_vld++;
        end
        checks++;
        if (saw_vld !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_vld got=%0d pulses want=0", saw_vld);
        end
        drive_op(8'h05, 8'h03, 1'b0, lat, got);
        checks++;
        if (got !== {1'b0, 1'b0, 8'h02} || lat !== 3) begin
            failures++;
            $display("FAIL reset_mid_next got=%b lat=%0d want=%b lat=3", got, lat, {1'b0, 1'b0, 8'h02});
        end
        consume();
    endtask

    initial begin
        rst = 1'b1;
        #1;
        checks++;
        if (o_vld !== 1'b0 || o_rdy !== 1'b1 || o_res !== 8'h00 || o_bor !== 1'b0 || o_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_init vld=%b rdy=%b res=%h bor=%b ovf=%b want 0 1 00 0 0",
                     o_vld, o_rdy, o_res, o_bor, o_ovf);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid_calc();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/subtractor_xbit_serial.md
# subtractor_xbit_serial

Multi-cycle, slice-serial subtractor computing `o_res = i_num_a - i_num_b - i_bor` over `DATA_WIDTH` bits, `SLICE_WIDTH` bits per clock. The borrow is carried between cycles. It is the subtract-direction companion to the team's combinational carry-lookahead adder, and reuses `adder_xbit_ahead` (instantiated with `DATA_WIDTH = SLICE_WIDTH`) as its per-slice datapath. It sits behind a valid/ready request port and a valid/ready result port, for area-constrained ALU and address paths.

## Interface
- `DATA_WIDTH`, default 32: operand/result width. Must be an integer multiple of `SLICE_WIDTH`.
- `SLICE_WIDTH`, default 4: bits processed per cycle. N = `DATA_WIDTH / SLICE_WIDTH`.
- `i_clk`  input  1  clock; all state changes on its rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high.
- `i_vld`  input  1  request valid.
- `o_rdy`  output  1  request ready. High only in IDLE.
- `i_num_a`  input  `DATA_WIDTH`  minuend.
- `i_num_b`  input  `DATA_WIDTH`  subtrahend.
- `i_bor`  input  1  borrow in.
- `o_vld`  output  1  result valid. High only in DONE.
- `i_rdy`  input  1  result ready from the consumer.
- `o_res`  output  `DATA_WIDTH`  difference, modulo 2^`DATA_WIDTH`.
- `o_bor`  output  1  borrow out. 1 iff unsigned a < b + bor.
- `o_ovf`  output  1  signed two's-complement overflow.

## Operation
- **FSM states:** IDLE, CALC, DONE.
  - IDLE → CALC on `i_vld && o_rdy`. `i_num_a`, `i_num_b` and `i_bor` are captured into internal registers; the slice counter is cleared.
  - CALC → DONE after slice N-1 is computed.
  - DONE → IDLE on `i_rdy`.
- **Per-slice arithmetic (slice k):**
  - Computed as a[k] + ~b[k] + ~borrow_k through the lookahead adder, where borrow_0 = captured `i_bor`.
  - borrow_{k+1} = ~carry_out. Result slice k is written into the result register.
- **Final flags, latched on the last slice:**
  - `o_bor` = borrow_N.
  - `o_ovf` = carry into MSB XOR carry out of MSB, taken from the last slice. This is equivalent to the (`DATA_WIDTH`+1)-bit sign-extended exact difference having unequal top two bits.
- **Input isolation:** changes on the input operands after capture have no effect. `i_vld` outside IDLE is ignored; no request is queued.
- **Output hold:** `o_res`, `o_bor` and `o_ovf` are registered and held stable from DONE entry until the next capture. They keep their last value in IDLE.
- **Reset:** asserting `i_rst` at any time, including mid-CALC or in DONE, forces IDLE immediately and discards the in-flight operation.
  - Reset values: `o_vld` = 0, `o_rdy` = 1, `o_res` = 0, `o_bor` = 0, `o_ovf` = 0, counter = 0, internal borrow = 0.

## Timing
- **Accept:** request handshake at rising edge T0.
- **Compute:** CALC occupies cycles T0+1 … T0+N. Slice k is registered at the edge ending cycle T0+1+k.
- **Result:** `o_vld` rises in cycle T0+N+1, so latency is N+1 cycles from accept to valid.
- **Release:** on the edge where `o_vld && i_rdy`, the state returns to IDLE and `o_rdy` is high the following cycle. The earliest next accept is one cycle after result consumption; throughput is one operation per N+2 cycles at best.
- **Backpressure:** with `i_rdy` low, the block stays in DONE indefinitely with outputs constant.
- **Combinational paths:** `o_rdy` and `o_vld` are decoded from the state register only. There is no combinational path from `i_vld` or `i_rdy` to any output.
- **Degenerate case:** N = 1 (`SLICE_WIDTH == DATA_WIDTH`) is legal, with one CALC cycle and latency 2.

## Test plan
All scenarios use `DATA_WIDTH` = 8, `SLICE_WIDTH` = 4 (N = 2).
- **Reset:** assert `i_rst` asynchronously mid-cycle → `o_vld` = 0, `o_rdy` = 1, `o_res` = 0x00, `o_bor` = 0, `o_ovf` = 0 without waiting for a clock edge.
- **Basic, cross-slice borrow, latency:**
  - a=0x05, b=0x03, bor=0 → `o_res` = 0x02, `o_bor` = 0, `o_ovf` = 0, `o_vld` in cycle T0+3.
  - a=0x10, b=0x01, bor=0 → `o_res` = 0x0F (borrow crosses the slice boundary).
- **Borrow out and borrow in:**
  - a=0x00, b=0x01, bor=0 → `o_res` = 0xFF, `o_bor` = 1, `o_ovf` = 0.
  - a=0x00, b=0x7F, bor=1 → `o_res` = 0x80, `o_bor` = 1, `o_ovf` = 0.
- **Signed overflow:**
  - a=0x80, b=0x01, bor=0 → `o_res` = 0x7F, `o_bor` = 0, `o_ovf` = 1.
  - a=0x7F, b=0xFF, bor=0 → `o_res` = 0x80, `o_bor` = 1, `o_ovf` = 1.
- **Backpressure and ignored requests:** hold `i_rdy` = 0 for 5 cycles in DONE while toggling `i_vld`, `i_num_a` and `i_num_b`.
  - Outputs stay constant and `o_rdy` stays 0.
  - After `i_rdy` pulses, `o_rdy` = 1 next cycle and a new request completes correctly.
- **Reset mid-operation:** pulse `i_rst` during CALC.
  - The block returns to IDLE with outputs cleared and no `o_vld` pulse.
  - A following request a=0x05, b=0x03 returns 0x02.
